frac_decim_macc_sched: RTL and testbench

Multi-channel scheduler that shares one MACC, one coefficient bank and one channel-partitioned data bank among `NumChannels` independent L/M fractional-decimation streams. It tracks write pointers, the polyphase phase and input credit for each channel, and arbitrates pending outputs. For each granted output it issues the data/coefficient read-address sequence and the `StartAcc_o` marker. It sits between the sample input mux and the shared MACC/round datapath.

---
 rtl/frac_decim_macc_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_frac_decim_macc_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_decim_macc_sched.sv
`default_nettype none
// ============================================================================
// Module   : frac_decim_macc_sched
// Brief    : Shares one MACC, coefficient bank and data bank among NumChannels
//            L/M fractional decimators. FRAC_DECIM_SCHED_ROUND_ROBIN_EN selects
//            round-robin arbitration instead of fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module frac_decim_macc_sched #(
  parameter int  NumChannels    = 2,
  parameter int  FilterLength   = 16,
  parameter int  AddrWidth      = 4,
  parameter int  InterpolationK = 2,
  parameter int  DecimationK    = 3,
  parameter int  PipeLatency    = 3,
  localparam int CW             = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  input  logic                    DataNd_i,
  input  logic [CW-1:0]           DataChan_i,
  output logic [CW+AddrWidth-1:0] DataAddrWr_o,
  output logic [CW+AddrWidth-1:0] DataAddr_o,
  output logic [AddrWidth-1:0]    CoeffAddr_o,
  output logic                    StartAcc_o,
  output logic                    Busy_o,
  output logic                    DataValid_o,
  output logic [CW-1:0]           ChanOut_o,
  output logic                    Overrun_o
);

  localparam int c_TAPS  = FilterLength / InterpolationK;
  localparam int c_KW    = (c_TAPS > 1) ? $clog2(c_TAPS) : 1;
  localparam int c_PW    = (InterpolationK > 1) ? $clog2(InterpolationK) : 1;
  localparam int c_NW    = $clog2(DecimationK + InterpolationK) + 1;
  localparam int c_DELAY = c_TAPS - 1 + PipeLatency;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [AddrWidth-1:0]    r_wrPtr [NumChannels];
  logic [AddrWidth-1:0]    r_base  [NumChannels];
  logic [c_PW-1:0]         r_phase [NumChannels];
  logic [c_NW-1:0]         r_need  [NumChannels];
  logic [NumChannels-1:0]  r_pending;
  logic                    r_overrun;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [c_KW-1:0]         r_k;
  logic [CW+AddrWidth-1:0] r_dataAddr;
  logic [AddrWidth-1:0]    r_coeffAddr;
  logic                    r_startAcc;
  logic [c_DELAY-1:0]      r_validSr;
  logic [CW-1:0]           r_chanSr [c_DELAY];

  logic                    w_anyPending;
  logic                    w_grant;
  logic [CW-1:0]           w_grantChan;
  logic [CW-1:0]           w_cand;
  logic                    w_lastTap;
  int                      w_sum;
  logic [c_NW-1:0]         w_newNeed;
  logic [c_PW-1:0]         w_newPhase;

`ifdef FRAC_DECIM_SCHED_ROUND_ROBIN_EN
  logic [CW-1:0]           r_rrPtr;
`endif

  assign w_anyPending = |r_pending;
  assign w_lastTap    = (r_k == c_KW'(c_TAPS - 1));

  // Descending scan: the last hit is the first candidate in search order.
  always_comb begin
    w_grantChan = '0;
    w_cand      = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
`ifdef FRAC_DECIM_SCHED_ROUND_ROBIN_EN
      w_cand = CW'((int'(r_rrPtr) + i) % NumChannels);
`else
      w_cand = CW'(i);
`endif
      if (r_pending[w_cand]) begin
        w_grantChan = w_cand;
      end
    end
  end

  always_comb begin
    w_sum      = int'(r_phase[w_grantChan]) + DecimationK;
    w_newNeed  = c_NW'(w_sum / InterpolationK);
    w_newPhase = c_PW'(w_sum % InterpolationK);
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A new grant may be taken in the last tap cycle so jobs run back-to-back.
  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_anyPending) begin
          w_grant     = 1'b1;
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_lastTap) begin
          if (w_anyPending) begin
            w_grant = 1'b1;
          end else begin
            w_stateNext = S_IDLE;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        r_wrPtr[c] <= '0;
        r_base[c]  <= '0;
        r_phase[c] <= '0;
        r_need[c]  <= c_NW'(1);
      end
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (DataNd_i) begin
        r_wrPtr[DataChan_i] <= r_wrPtr[DataChan_i] + AddrWidth'(1);
        if (r_need[DataChan_i] == c_NW'(1)) begin
          r_need[DataChan_i]    <= '0;
          r_pending[DataChan_i] <= 1'b1;
          r_base[DataChan_i]    <= r_wrPtr[DataChan_i];
        end else if (r_need[DataChan_i] > c_NW'(1)) begin
          r_need[DataChan_i] <= r_need[DataChan_i] - c_NW'(1);
        end else if (r_pending[DataChan_i]) begin
          r_overrun <= 1'b1;
        end
      end
      if (w_grant) begin
        r_pending[w_grantChan] <= 1'b0;
        r_need[w_grantChan]    <= w_newNeed;
        r_phase[w_grantChan]   <= w_newPhase;
      end
    end
  end

`ifdef FRAC_DECIM_SCHED_ROUND_ROBIN_EN
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_rrPtr <= '0;
    end else if (w_grant) begin
      r_rrPtr <= (w_grantChan == CW'(NumChannels - 1)) ? '0 : w_grantChan + CW'(1);
    end
  end
`endif

  // Addresses step by walking the data pointer back and the coefficient up by L.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_k         <= '0;
      r_dataAddr  <= '0;
      r_coeffAddr <= '0;
      r_startAcc  <= 1'b0;
    end else if (w_grant) begin
      r_k         <= '0;
      r_dataAddr  <= {w_grantChan, r_base[w_grantChan]};
      r_coeffAddr <= AddrWidth'(r_phase[w_grantChan]);
      r_startAcc  <= 1'b1;
    end else if ((r_state == S_RUN) && !w_lastTap) begin
      r_k                        <= r_k + c_KW'(1);
      r_dataAddr[AddrWidth-1:0]  <= r_dataAddr[AddrWidth-1:0] - AddrWidth'(1);
      r_coeffAddr                <= r_coeffAddr + AddrWidth'(InterpolationK);
      r_startAcc                 <= 1'b0;
    end else begin
      r_k         <= '0;
      r_dataAddr  <= '0;
      r_coeffAddr <= '0;
      r_startAcc  <= 1'b0;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_validSr <= '0;
      for (int i = 0; i < c_DELAY; i++) begin
        r_chanSr[i] <= '0;
      end
    end else begin
      r_validSr[0] <= r_startAcc;
      r_chanSr[0]  <= r_dataAddr[CW+AddrWidth-1:AddrWidth];
      for (int i = 1; i < c_DELAY; i++) begin
        r_validSr[i] <= r_validSr[i-1];
        r_chanSr[i]  <= r_chanSr[i-1];
      end
    end
  end

  assign DataAddrWr_o = {DataChan_i, r_wrPtr[DataChan_i]};
  assign DataAddr_o   = r_dataAddr;
  assign CoeffAddr_o  = r_coeffAddr;
  assign StartAcc_o   = r_startAcc;
  assign Busy_o       = (r_state == S_RUN);
  assign DataValid_o  = r_validSr[c_DELAY-1];
  assign ChanOut_o    = r_validSr[c_DELAY-1] ? r_chanSr[c_DELAY-1] : '0;
  assign Overrun_o    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_frac_decim_macc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frac_decim_macc_sched
// Brief    : Self-checking bench: directed vectors plus random traffic against
//            a cycle-level reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frac_decim_macc_sched;
  localparam int NC = 2, FL = 16, AW = 4, L = 2, M = 3, PL = 3, CW = 1;
  localparam int T = FL / L;
  localparam int D = T - 1 + PL;

  logic          Clk_i = 1'b0;
  logic          Rst_i;
  logic          DataNd_i;
  logic [CW-1:0] DataChan_i;
  logic [CW+AW-1:0] DataAddrWr_o, DataAddr_o;
  logic [AW-1:0] CoeffAddr_o;
  logic          StartAcc_o, Busy_o, DataValid_o, Overrun_o;
  logic [CW-1:0] ChanOut_o;

  frac_decim_macc_sched dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .DataNd_i(DataNd_i), .DataChan_i(DataChan_i),
    .DataAddrWr_o(DataAddrWr_o), .DataAddr_o(DataAddr_o), .CoeffAddr_o(CoeffAddr_o),
    .StartAcc_o(StartAcc_o), .Busy_o(Busy_o), .DataValid_o(DataValid_o),
    .ChanOut_o(ChanOut_o), .Overrun_o(Overrun_o)
  );

  always #5 Clk_i = ~Clk_i;

  int nPass = 0, nTotal = 0;

  task automatic chk(input string name, input int act, input int exp);
    nTotal++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: per-channel bookkeeping and job timeline by formula.
  int mWr[NC], mPhase[NC], mNeed[NC], mBase[NC];
  bit mPend[NC];
  bit mRun, mOvr;
  int mK, mG, mB, mP, mRr, cyc;
  int validAt[$], validCh[$];
  int stCh[$], stCoeff[$], stAddr[$];
  int busyCycles, validCount;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mWr[c] = 0; mPhase[c] = 0; mNeed[c] = 1; mBase[c] = 0; mPend[c] = 0;
    end
    mRun = 0; mOvr = 0; mK = 0; mG = 0; mB = 0; mP = 0; mRr = 0;
    validAt.delete(); validCh.delete();
  endtask

  task automatic model_step(input bit nd, input int ch);
    int g, c;
    cyc++;
    g = -1;
    if (!mRun || mK == T - 1) begin
      for (int i = 0; i < NC; i++) begin
`ifdef FRAC_DECIM_SCHED_ROUND_ROBIN_EN
        c = (mRr + i) % NC;
`else
        c = i;
`endif
        if (g < 0 && mPend[c]) g = c;
      end
    end
    if (nd) begin
      if (mNeed[ch] == 0 && mPend[ch]) mOvr = 1;
      if (mNeed[ch] == 1) begin
        mNeed[ch] = 0; mPend[ch] = 1; mBase[ch] = mWr[ch];
      end else if (mNeed[ch] > 1) begin
        mNeed[ch]--;
      end
      mWr[ch] = (mWr[ch] + 1) % FL;
    end
    if (g >= 0) begin
      mPend[g] = 0; mRun = 1; mK = 0; mG = g; mB = mBase[g]; mP = mPhase[g];
      mNeed[g] = (mPhase[g] + M) / L;
      mPhase[g] = (mPhase[g] + M) % L;
      mRr = (g + 1) % NC;
      validAt.push_back(cyc + D);
      validCh.push_back(g);
    end else if (mRun) begin
      if (mK == T - 1) mRun = 0;
      else mK++;
    end
  endtask

  task automatic check_outputs();
    bit expValid;
    int expCh, dmy;
    expValid = 0; expCh = 0;
    if (validAt.size() > 0 && validAt[0] == cyc) begin
      expValid = 1;
      expCh = validCh.pop_front();
      dmy = validAt.pop_front();
    end
    chk("busy", int'(Busy_o), int'(mRun));
    chk("start_acc", int'(StartAcc_o), int'(mRun && mK == 0));
    chk("data_valid", int'(DataValid_o), int'(expValid));
    chk("overrun", int'(Overrun_o), int'(mOvr));
    if (mRun) begin
      chk("data_addr", int'(DataAddr_o), (mG << AW) | ((mB - mK) & (FL - 1)));
      chk("coeff_addr", int'(CoeffAddr_o), mP + mK * L);
    end
    if (expValid) chk("chan_out", int'(ChanOut_o), expCh);
    if (StartAcc_o) begin
      stCh.push_back(int'(DataAddr_o[AW +: CW]));
      stCoeff.push_back(int'(CoeffAddr_o));
      stAddr.push_back(int'(DataAddr_o[AW-1:0]));
    end
    if (Busy_o) busyCycles++;
    if (DataValid_o) validCount++;
  endtask

  task automatic tick(input bit nd, input int ch, input int tblWr = -1);
    DataNd_i = nd;
    DataChan_i = CW'(ch);
    #1;
    if (nd) chk("wr_addr", int'(DataAddrWr_o), (ch << AW) | mWr[ch]);
    if (tblWr >= 0) chk("wr_addr_vec", int'(DataAddrWr_o), tblWr);
    @(posedge Clk_i);
    model_step(nd, ch);
    #1;
    DataNd_i = 1'b0;
    check_outputs();
  endtask

  task automatic doReset();
    Rst_i = 1'b1;
    DataNd_i = 1'b0;
    DataChan_i = '0;
    model_reset();
    @(posedge Clk_i);
    #1;
    Rst_i = 1'b0;
  endtask

  typedef struct {
    bit nd; int ch; int wr;
    bit busy; bit start; int addr; int coeff; bit valid;
  } vec_t;

  function automatic vec_t mk(bit nd, int ch, int wr, bit busy, bit start,
                              int addr, int coeff, bit valid);
    vec_t v;
    v.nd = nd; v.ch = ch; v.wr = wr; v.busy = busy; v.start = start;
    v.addr = addr; v.coeff = coeff; v.valid = valid;
    return v;
  endfunction

  vec_t tbl[13];
  int   expPh[5]   = '{0, 1, 0, 1, 0};
  int   expBase[5] = '{0, 1, 3, 4, 6};
  int   expSecond, guard, n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 0, 0,  0, 0, -1, -1, 0);
    tbl[1]  = mk(0, 0, -1, 1, 1,  0,  0, 0);
    tbl[2]  = mk(0, 0, -1, 1, 0, 15,  2, 0);
    tbl[3]  = mk(0, 0, -1, 1, 0, 14,  4, 0);
    tbl[4]  = mk(0, 0, -1, 1, 0, 13,  6, 0);
    tbl[5]  = mk(0, 0, -1, 1, 0, 12,  8, 0);
    tbl[6]  = mk(0, 0, -1, 1, 0, 11, 10, 0);
    tbl[7]  = mk(0, 0, -1, 1, 0, 10, 12, 0);
    tbl[8]  = mk(0, 0, -1, 1, 0,  9, 14, 0);
    tbl[9]  = mk(0, 0, -1, 0, 0, -1, -1, 0);
    tbl[10] = mk(0, 0, -1, 0, 0, -1, -1, 0);
    tbl[11] = mk(0, 0, -1, 0, 0, -1, -1, 1);
    tbl[12] = mk(0, 0, -1, 0, 0, -1, -1, 0);

    Rst_i = 1'b1; DataNd_i = 1'b0; DataChan_i = '0; cyc = 0;
    model_reset();
    repeat (2) @(posedge Clk_i);
    #1;
    chk("rst_busy", int'(Busy_o), 0);
    chk("rst_start", int'(StartAcc_o), 0);
    chk("rst_data_addr", int'(DataAddr_o), 0);
    chk("rst_coeff", int'(CoeffAddr_o), 0);
    chk("rst_valid", int'(DataValid_o), 0);
    chk("rst_chan_out", int'(ChanOut_o), 0);
    chk("rst_overrun", int'(Overrun_o), 0);
    chk("rst_wr_addr", int'(DataAddrWr_o), 0);
    Rst_i = 1'b0;

    // Single ch0 sample, directed vectors
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].nd, tbl[i].ch, tbl[i].wr);
      chk("vec_busy", int'(Busy_o), int'(tbl[i].busy));
      chk("vec_start", int'(StartAcc_o), int'(tbl[i].start));
      chk("vec_valid", int'(DataValid_o), int'(tbl[i].valid));
      if (tbl[i].addr >= 0) chk("vec_data_addr", int'(DataAddr_o), tbl[i].addr);
      if (tbl[i].coeff >= 0) chk("vec_coeff", int'(CoeffAddr_o), tbl[i].coeff);
      if (tbl[i].valid) chk("vec_chan_out", int'(ChanOut_o), 0);
    end

    // Seven ch0 samples spaced 20 cycles: jobs on inputs 1,2,4,5,7
    doReset();
    stCh.delete(); stCoeff.delete(); stAddr.delete();
    for (int s = 0; s < 7; s++) begin
      tick(1, 0);
      repeat (19) tick(0, 0);
    end
    chk("phase_job_count", stCoeff.size(), 5);
    for (int j = 0; j < 5 && j < stCoeff.size(); j++) begin
      chk("phase_coeff", stCoeff[j], expPh[j]);
      chk("phase_base", stAddr[j], expBase[j]);
    end

    // Both channels pending at the end of a ch0 job, three rounds
`ifdef FRAC_DECIM_SCHED_ROUND_ROBIN_EN
    expSecond = 1;
`else
    expSecond = 0;
`endif
    doReset();
    for (int r = 0; r < 3; r++) begin
      stCh.delete();
      busyCycles = 0;
      n = mNeed[0];
      repeat (n) tick(1, 0);
      guard = 0;
      while (!mRun && guard < 10) begin tick(0, 0); guard++; end
      n = mNeed[1];
      repeat (n) tick(1, 1);
      n = mNeed[0];
      repeat (n) tick(1, 0);
      guard = 0;
      while (mRun && guard < 100) begin tick(0, 0); guard++; end
      chk("b2b_busy_cycles", busyCycles, 3 * T);
      chk("b2b_job_count", stCh.size(), 3);
      if (stCh.size() == 3) begin
        chk("b2b_first", stCh[0], 0);
        chk("b2b_second", stCh[1], expSecond);
        chk("b2b_third", stCh[2], 1 - expSecond);
      end
      repeat (D) tick(0, 0);
    end

    // Overrun: ch0 samples on consecutive cycles during a ch1 job
    doReset();
    tick(1, 1);
    tick(0, 0);
    tick(1, 0);
    chk("overrun_before", int'(Overrun_o), 0);
    tick(1, 0);
    chk("overrun_set", int'(Overrun_o), 1);
    repeat (30) tick(0, 0);
    chk("overrun_sticky", int'(Overrun_o), 1);
    doReset();
    chk("overrun_cleared", int'(Overrun_o), 0);

    // Asynchronous reset at k=4 of a job
    doReset();
    tick(1, 0);
    tick(0, 0);
    repeat (4) tick(0, 0);
    chk("abort_k4_addr", int'(DataAddr_o), 12);
    Rst_i = 1'b1;
    #1;
    chk("abort_busy", int'(Busy_o), 0);
    chk("abort_start", int'(StartAcc_o), 0);
    chk("abort_data_addr", int'(DataAddr_o), 0);
    chk("abort_coeff", int'(CoeffAddr_o), 0);
    chk("abort_valid", int'(DataValid_o), 0);
    chk("abort_chan_out", int'(ChanOut_o), 0);
    model_reset();
    @(posedge Clk_i);
    #1;
    Rst_i = 1'b0;
    validCount = 0;
    repeat (20) tick(0, 0);
    chk("abort_no_valid", validCount, 0);
    tick(1, 0, 0);

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 1500; i++) tick($urandom_range(0, 11) == 0, $urandom_range(0, 1));
    doReset();
    for (int i = 0; i < 1500; i++) tick($urandom_range(0, 3) == 0, $urandom_range(0, 1));

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
`default_nettype wire
